// File: rtl/vtage_update_ctrl.sv
// VTAGE commit-side update controller: evaluates resolved-value feedback
// and pulses per-table entry updates. Optional macro: VTAGE_ALLOC_RAND_EN.
module vtage_update_ctrl #(
    parameter int P_NUM_TABLES   = 4,
    parameter int LP_INDEX_WIDTH = 8,
    parameter int P_CONF_WIDTH   = 8,
    parameter int P_TAG_WIDTH    = 8,
    parameter int P_U_WIDTH      = 2
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    input  logic                                        fb_valid_i,
    output logic                                        fb_ready_o,
    input  logic [P_NUM_TABLES*P_TAG_WIDTH-1:0]         fb_tag_i,
    input  logic [LP_INDEX_WIDTH-1:0]                   fb_value_i,
    output logic [P_NUM_TABLES*P_TAG_WIDTH-1:0]         ent_fb_tag_o,
    input  logic [P_NUM_TABLES-1:0]                     ent_tag_match_i,
    input  logic [P_NUM_TABLES-1:0]                     ent_alloc_avail_i,
    input  logic [P_NUM_TABLES*LP_INDEX_WIDTH-1:0]      ent_value_i,
    input  logic [P_NUM_TABLES*(P_CONF_WIDTH+1)-1:0]    ent_conf_i,
    output logic [P_NUM_TABLES-1:0]                     ud_incr_conf_o,
    output logic [P_NUM_TABLES-1:0]                     ud_rst_conf_o,
    output logic [P_NUM_TABLES-1:0]                     ud_incr_use_o,
    output logic [P_NUM_TABLES-1:0]                     ud_decr_use_o,
    output logic [P_NUM_TABLES-1:0]                     ud_rst_use_o,
    output logic [P_NUM_TABLES-1:0]                     ud_load_tag_o,
    output logic [P_NUM_TABLES-1:0]                     ud_load_value_o,
    output logic [P_NUM_TABLES*P_TAG_WIDTH-1:0]         ud_tag_o,
    output logic [LP_INDEX_WIDTH-1:0]                   ud_value_o,
    output logic                                        alloc_fail_o
);

    localparam int NT = P_NUM_TABLES;
    localparam int VW = LP_INDEX_WIDTH;
    localparam int CW = P_CONF_WIDTH + 1;
    localparam int TW = P_TAG_WIDTH;

    if (P_U_WIDTH < 1) begin : g_bad_u_width
        $error("P_U_WIDTH must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_EVAL,
        S_UPDATE
    } state_e;

    state_e              state_q;
    logic [NT*TW-1:0]    tag_q;
    logic [VW-1:0]       value_q;

    logic [NT-1:0]       incr_conf_q, incr_conf_d;
    logic [NT-1:0]       rst_conf_q, rst_conf_d;
    logic [NT-1:0]       incr_use_q, incr_use_d;
    logic [NT-1:0]       decr_use_q, decr_use_d;
    logic [NT-1:0]       rst_use_q, rst_use_d;
    logic [NT-1:0]       load_tag_q, load_tag_d;
    logic [NT-1:0]       load_value_q, load_value_d;
    logic [NT*TW-1:0]    ud_tag_q, ud_tag_d;
    logic [VW-1:0]       ud_value_q, ud_value_d;
    logic                fail_q, fail_d;

    logic                hit;
    logic                correct;
    logic                above;
    int                  prov;
    int                  sel;
    int                  n_cand;
    logic [CW-1:0]       prov_conf;
    logic [NT-1:0]       cand;

`ifdef VTAGE_ALLOC_RAND_EN
    logic [7:0]          lfsr_q;
    int                  second;

    // Fibonacci LFSR, taps 8,6,5,4; free-running to spread allocations.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end
`endif

    always_comb begin
        hit    = 1'b0;
        prov   = 0;
        for (int i = 0; i < NT; i++) begin
            if (ent_tag_match_i[i]) begin
                hit  = 1'b1;
                prov = i;
            end
        end
        prov_conf = ent_conf_i[prov*CW +: CW];
        correct   = hit && (ent_value_i[prov*VW +: VW] == value_q);
        above     = !hit || (prov < NT - 1);

        cand   = '0;
        sel    = 0;
        n_cand = 0;
`ifdef VTAGE_ALLOC_RAND_EN
        second = 0;
`endif
        for (int j = 0; j < NT; j++) begin
            cand[j] = ent_alloc_avail_i[j] && (!hit || j > prov);
            if (cand[j]) begin
                if (n_cand == 0) sel = j;
`ifdef VTAGE_ALLOC_RAND_EN
                else if (n_cand == 1) second = j;
`endif
                n_cand = n_cand + 1;
            end
        end
`ifdef VTAGE_ALLOC_RAND_EN
        if (n_cand >= 2 && lfsr_q[0]) sel = second;
`endif

        incr_conf_d  = '0;
        rst_conf_d   = '0;
        incr_use_d   = '0;
        decr_use_d   = '0;
        rst_use_d    = '0;
        load_tag_d   = '0;
        load_value_d = '0;
        ud_tag_d     = '0;
        fail_d       = 1'b0;

        if (correct) begin
            incr_conf_d[prov] = 1'b1;
            incr_use_d[prov]  = prov_conf[CW-1];
        end else begin
            if (hit) begin
                rst_conf_d[prov]   = 1'b1;
                decr_use_d[prov]   = 1'b1;
                load_value_d[prov] = (prov_conf == '0);
            end
            if (|cand) begin
                load_tag_d[sel]       = 1'b1;
                load_value_d[sel]     = 1'b1;
                rst_conf_d[sel]       = 1'b1;
                rst_use_d[sel]        = 1'b1;
                ud_tag_d[sel*TW +: TW] = tag_q[sel*TW +: TW];
            end else if (above) begin
                // Nothing free above the provider: age every higher entry.
                for (int j = 0; j < NT; j++) begin
                    if (!hit || j > prov) decr_use_d[j] = 1'b1;
                end
                fail_d = 1'b1;
            end
        end
        ud_value_d = (|load_value_d) ? value_q : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            tag_q        <= '0;
            value_q      <= '0;
            incr_conf_q  <= '0;
            rst_conf_q   <= '0;
            incr_use_q   <= '0;
            decr_use_q   <= '0;
            rst_use_q    <= '0;
            load_tag_q   <= '0;
            load_value_q <= '0;
            ud_tag_q     <= '0;
            ud_value_q   <= '0;
            fail_q       <= 1'b0;
        end else begin
            incr_conf_q  <= '0;
            rst_conf_q   <= '0;
            incr_use_q   <= '0;
            decr_use_q   <= '0;
            rst_use_q    <= '0;
            load_tag_q   <= '0;
            load_value_q <= '0;
            ud_tag_q     <= '0;
            ud_value_q   <= '0;
            fail_q       <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (fb_valid_i) begin
                        tag_q   <= fb_tag_i;
                        value_q <= fb_value_i;
                        state_q <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    incr_conf_q  <= incr_conf_d;
                    rst_conf_q   <= rst_conf_d;
                    incr_use_q   <= incr_use_d;
                    decr_use_q   <= decr_use_d;
                    rst_use_q    <= rst_use_d;
                    load_tag_q   <= load_tag_d;
                    load_value_q <= load_value_d;
                    ud_tag_q     <= ud_tag_d;
                    ud_value_q   <= ud_value_d;
                    fail_q       <= fail_d;
                    state_q      <= S_UPDATE;
                end
                S_UPDATE: state_q <= S_IDLE;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    assign fb_ready_o      = (state_q == S_IDLE) & ~rst_i;
    assign ent_fb_tag_o    = tag_q;
    assign ud_incr_conf_o  = incr_conf_q;
    assign ud_rst_conf_o   = rst_conf_q;
    assign ud_incr_use_o   = incr_use_q;
    assign ud_decr_use_o   = decr_use_q;
    assign ud_rst_use_o    = rst_use_q;
    assign ud_load_tag_o   = load_tag_q;
    assign ud_load_value_o = load_value_q;
    assign ud_tag_o        = ud_tag_q;
    assign ud_value_o      = ud_value_q;
    assign alloc_fail_o    = fail_q;

endmodule
